prog_sequencer: RTL and testbench
=================================

Name: prog_sequencer

Overview:
- Programmable successor to the hard-wired datapath sequencer.
- Steps through a loadable instruction table and drives the register-file/ALU control signals: immediate select, load enable/address, read ports A/B, immediate, opcode.
- Supports jumps, a counted loop, halt, and single-step mode. Widths, register count and program depth are parametrised.
- Sits between the host/test harness (loads the program, starts it) and the register file + ALU datapath.

Parameters:
- DATA_W, 8, immediate width.
- OP_W, 8, ALU opcode width.
- NREGS, 16, register count. AW = $clog2(NREGS) is derived, not overridable.
- DEPTH, 32, program entries. PC_W = $clog2(DEPTH) is derived.
- LOOP_W, 8, loop counter width.
- INSTR_W is derived: 2+1+1+3*AW+DATA_W+OP_W.

Ports:
- clk  in  1  clock.
- clr  in  1  synchronous active-high reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  PC_W  program write address.
- prog_wdata  in  INSTR_W  instruction word.
- start  in  1  begin execution at pc 0.
- loop_init  in  LOOP_W  loop counter value, latched on accepted start.
- step_mode  in  1  1 = execute one instruction per step pulse.
- step  in  1  single-step advance.
- busy  out  1  state is RUN or WAIT_STEP.
- done  out  1  state is HALTED.
- pc  out  PC_W  current program counter.
- sel_imm  out  1  ALU B operand = imm.
- ld_en  out  1  register write enable.
- ld_reg  out  AW  register write address.
- rd_a, rd_b  out  AW  register read addresses.
- imm  out  DATA_W  immediate.
- op  out  OP_W  ALU opcode.

Behaviour:
- Instruction word, MSB first: kind[1:0], sel_imm, wr_en, wr_addr, ra, rb, imm, op.
- kind encodings: EXEC=00, JUMP=01, HALT=10, LOOP=11. JUMP/LOOP take their target from imm[PC_W-1:0].
- States: IDLE, RUN, WAIT_STEP, HALTED.
- Reset: state=IDLE, pc=0, loop_cnt=0, busy=0, done=0. All control outputs are 0, including ld_en.
- Reset does not clear program memory (memory has no reset).
- Program writes: prog_we is honoured only in IDLE or HALTED; writes are silently dropped while busy.
- Start: accepted in IDLE or HALTED. On that edge: pc←0, loop_cnt←loop_init, state←RUN (or WAIT_STEP if step_mode=1). start while busy is ignored.
- RUN: each edge consumes mem[pc]. Memory read is combinational; outputs are registered, so an instruction's controls are visible for exactly one cycle after the edge that consumes it.
  - EXEC: drive its fields; ld_en=wr_en; pc←pc+1.
  - JUMP: ld_en=0; pc←target.
  - LOOP: ld_en=0. If loop_cnt≠0: loop_cnt←loop_cnt−1, pc←target. Else fall through, pc←pc+1.
  - HALT: ld_en=0; state←HALTED.
- Non-EXEC cycles drive sel_imm=0, ld_reg/rd_a/rd_b/imm/op=0.
- End of program: EXEC or fall-through at pc=DEPTH−1 behaves as HALT (no wrap). The controls of that last EXEC are still issued.
- step_mode:
  - Sampled only on accepted start. Changing it mid-run has no effect.
  - In WAIT_STEP, outputs are idle (ld_en=0). A step pulse consumes one instruction exactly as in RUN, then the state returns to WAIT_STEP (or HALTED).
  - step held high = one instruction per cycle.
- HALTED: done=1, busy=0, controls idle, pc holds the HALT address. Remains until start or clr.
- Mid-run clr: abort immediately. An ld_en pulse already registered completes its cycle; none is issued after.
- Simultaneous clr and start: clr wins. Simultaneous prog_we and start in IDLE: both take effect; the write lands before the first fetch.

Decomposition:
- Package prog_seq_pkg holds:
  - kind codes (EXEC/JUMP/HALT/LOOP);
  - opcode constants ADD=8'b00000101, ADDI=8'b01010000, OR=8'b00000010;
  - state enum;
  - field-offset localparams/functions computing slice positions from AW/DATA_W/OP_W.
- Sub-module prog_seq_mem: DEPTH×INSTR_W storage, one synchronous write port, one asynchronous read port, no reset.

Test Plan:
- Fibonacci program (ADDI r0←1, ADDI r1←1, ADD r2..r15 with rd_a=k−1, rd_b=k−2, then HALT) at pc 0..16, start at edge E0 → ld_en high after E1..E16 with ld_reg=0..15; sel_imm=1 only for the two ADDIs; done=1 after E17, busy=0.
- LOOP: program EXEC wr r1, LOOP target 0, HALT; loop_init=3 → exactly 4 ld_en pulses to r1, then done. Same program with loop_init=0 → 1 pulse.
- Step mode: step_mode=1, Fibonacci program, step pulsed every 5 cycles → one ld_en per step, none between; ld_reg sequence 0..15; done after the 17th step.
- Write protection: prog_we to addr 3 while busy → no effect on the running program; after HALTED, the rewrite takes effect on the next start.
- Mid-run clr at the 6th EXEC → next cycle busy=0, pc=0, ld_en=0. Restart without reloading → identical 16-pulse sequence (memory retained).
- Boundary: program of DEPTH EXECs with no HALT → DEPTH ld_en pulses, then done=1. pc never wraps to 0. start while busy is ignored.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared definitions for the programmable sequencer.
//   - instruction kind codes and the opcode constants used by test programs
//   - sequencer state enum
//   - helpers that compute instruction field offsets from AW/DATA_W/OP_W
// Instruction word layout, MSB first:
//   kind[1:0] | sel_imm | wr_en | wr_addr[AW] | ra[AW] | rb[AW] | imm[DATA_W] | op[OP_W]
package prog_seq_pkg;

    typedef enum logic [1:0] {
        EXEC = 2'b00,
        JUMP = 2'b01,
        HALT = 2'b10,
        LOOP = 2'b11
    } kind_e;

    localparam logic [7:0] ADD  = 8'b0000_0101;
    localparam logic [7:0] ADDI = 8'b0101_0000;
    localparam logic [7:0] OR   = 8'b0000_0010;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        RUN       = 2'b01,
        WAIT_STEP = 2'b10,
        HALTED    = 2'b11
    } state_e;

    function automatic int instr_width(input int aw, input int data_w, input int op_w);
        return 4 + 3 * aw + data_w + op_w;
    endfunction

    // op sits at bit 0; every other field is stacked above it.
    function automatic int off_imm(input int op_w);
        return op_w;
    endfunction

    function automatic int off_rb(input int data_w, input int op_w);
        return op_w + data_w;
    endfunction

    function automatic int off_ra(input int aw, input int data_w, input int op_w);
        return op_w + data_w + aw;
    endfunction

    function automatic int off_wa(input int aw, input int data_w, input int op_w);
        return op_w + data_w + 2 * aw;
    endfunction

    function automatic int off_wen(input int aw, input int data_w, input int op_w);
        return op_w + data_w + 3 * aw;
    endfunction

    function automatic int off_sel(input int aw, input int data_w, input int op_w);
        return op_w + data_w + 3 * aw + 1;
    endfunction

    function automatic int off_kind(input int aw, input int data_w, input int op_w);
        return op_w + data_w + 3 * aw + 2;
    endfunction

endpackage

// File: rtl/prog_seq_mem.sv
// Program storage for the sequencer.
//   clk   : clock
//   we    : write strobe (already qualified by the sequencer)
//   waddr : write address
//   wdata : instruction word to store
//   raddr : fetch address (current pc)
//   rdata : instruction at raddr, combinational
// No reset: the program survives clr so a run can be restarted without reloading.
module prog_seq_mem #(
    parameter int DEPTH   = 32,
    parameter int INSTR_W = 32,
    localparam int PC_W   = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PC_W-1:0]    waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [PC_W-1:0]    raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Programmable sequencer driving register-file / ALU control.
//   clk, clr            : clock, synchronous active-high reset
//   prog_we/addr/wdata  : program load port (honoured only in IDLE or HALTED)
//   start, loop_init    : begin at pc 0, latch loop counter (IDLE or HALTED only)
//   step_mode, step     : single-step execution, mode sampled on start
//   busy, done          : RUN/WAIT_STEP, HALTED
//   pc                  : current program counter
//   sel_imm, ld_en, ld_reg, rd_a, rd_b, imm, op : registered datapath controls
// Each consuming edge fetches mem[pc] combinationally and registers that
// instruction's controls, so they are visible for exactly one cycle.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 8,
    parameter int NREGS   = 16,
    parameter int DEPTH   = 32,
    parameter int LOOP_W  = 8,
    localparam int AW      = $clog2(NREGS),
    localparam int PC_W    = $clog2(DEPTH),
    localparam int INSTR_W = instr_width(AW, DATA_W, OP_W)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               prog_we,
    input  logic [PC_W-1:0]    prog_addr,
    input  logic [INSTR_W-1:0] prog_wdata,
    input  logic               start,
    input  logic [LOOP_W-1:0]  loop_init,
    input  logic               step_mode,
    input  logic               step,
    output logic               busy,
    output logic               done,
    output logic [PC_W-1:0]    pc,
    output logic               sel_imm,
    output logic               ld_en,
    output logic [AW-1:0]      ld_reg,
    output logic [AW-1:0]      rd_a,
    output logic [AW-1:0]      rd_b,
    output logic [DATA_W-1:0]  imm,
    output logic [OP_W-1:0]    op
);

    localparam int O_IMM  = off_imm(OP_W);
    localparam int O_RB   = off_rb(DATA_W, OP_W);
    localparam int O_RA   = off_ra(AW, DATA_W, OP_W);
    localparam int O_WA   = off_wa(AW, DATA_W, OP_W);
    localparam int O_WEN  = off_wen(AW, DATA_W, OP_W);
    localparam int O_SEL  = off_sel(AW, DATA_W, OP_W);
    localparam int O_KIND = off_kind(AW, DATA_W, OP_W);

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(DEPTH - 1);

    state_e              state;
    logic [LOOP_W-1:0]   loop_cnt;
    logic [INSTR_W-1:0]  instr;
    logic                mem_we;
    logic                idle_like;
    logic                consume;
    logic                last_pc;

    kind_e               f_kind;
    logic                f_sel;
    logic                f_wen;
    logic [AW-1:0]       f_wa;
    logic [AW-1:0]       f_ra;
    logic [AW-1:0]       f_rb;
    logic [DATA_W-1:0]   f_imm;
    logic [OP_W-1:0]     f_op;
    logic [PC_W-1:0]     target;

    assign idle_like = (state == IDLE) || (state == HALTED);
    // Writes while a program runs are dropped so the running program cannot be corrupted.
    assign mem_we    = prog_we && idle_like;
    assign consume   = (state == RUN) || ((state == WAIT_STEP) && step);
    assign last_pc   = (pc == LAST_PC);

    prog_seq_mem #(
        .DEPTH   (DEPTH),
        .INSTR_W (INSTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc),
        .rdata (instr)
    );

    assign f_kind = kind_e'(instr[O_KIND +: 2]);
    assign f_sel  = instr[O_SEL];
    assign f_wen  = instr[O_WEN];
    assign f_wa   = instr[O_WA +: AW];
    assign f_ra   = instr[O_RA +: AW];
    assign f_rb   = instr[O_RB +: AW];
    assign f_imm  = instr[O_IMM +: DATA_W];
    assign f_op   = instr[0 +: OP_W];
    assign target = f_imm[PC_W-1:0];

    assign busy = (state == RUN) || (state == WAIT_STEP);
    assign done = (state == HALTED);

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            pc       <= '0;
            loop_cnt <= '0;
            sel_imm  <= 1'b0;
            ld_en    <= 1'b0;
            ld_reg   <= '0;
            rd_a     <= '0;
            rd_b     <= '0;
            imm      <= '0;
            op       <= '0;
        end else begin
            // Controls are idle unless an EXEC is consumed on this edge.
            sel_imm <= 1'b0;
            ld_en   <= 1'b0;
            ld_reg  <= '0;
            rd_a    <= '0;
            rd_b    <= '0;
            imm     <= '0;
            op      <= '0;

            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        pc       <= '0;
                        loop_cnt <= loop_init;
                        state    <= step_mode ? WAIT_STEP : RUN;
                    end
                end
                RUN, WAIT_STEP: begin
                    // The stepping mode is carried by the state itself, so a
                    // consumed instruction leaves state unchanged unless it halts.
                    if (consume) begin
                        case (f_kind)
                            EXEC: begin
                                sel_imm <= f_sel;
                                ld_en   <= f_wen;
                                ld_reg  <= f_wa;
                                rd_a    <= f_ra;
                                rd_b    <= f_rb;
                                imm     <= f_imm;
                                op      <= f_op;
                                // No wrap: running off the end halts at the last entry.
                                if (last_pc) begin
                                    state <= HALTED;
                                end else begin
                                    pc <= pc + 1'b1;
                                end
                            end
                            JUMP: begin
                                pc <= target;
                            end
                            LOOP: begin
                                if (loop_cnt != '0) begin
                                    loop_cnt <= loop_cnt - 1'b1;
                                    pc       <= target;
                                end else if (last_pc) begin
                                    state <= HALTED;
                                end else begin
                                    pc <= pc + 1'b1;
                                end
                            end
                            HALT: begin
                                state <= HALTED;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Scoreboard bench for prog_sequencer: a program-level reference model predicts
// the ordered list of register writes, a monitor pops and compares on each ld_en.
module tb_prog_sequencer;
    import prog_seq_pkg::*;

    localparam int DATA_W  = 8;
    localparam int OP_W    = 8;
    localparam int NREGS   = 16;
    localparam int DEPTH   = 32;
    localparam int LOOP_W  = 8;
    localparam int AW      = 4;
    localparam int PC_W    = 5;
    localparam int INSTR_W = 32;

    logic               clk;
    logic               clr;
    logic               prog_we;
    logic [PC_W-1:0]    prog_addr;
    logic [INSTR_W-1:0] prog_wdata;
    logic               start;
    logic [LOOP_W-1:0]  loop_init;
    logic               step_mode;
    logic               step;
    logic               busy;
    logic               done;
    logic [PC_W-1:0]    pc;
    logic               sel_imm;
    logic               ld_en;
    logic [AW-1:0]      ld_reg;
    logic [AW-1:0]      rd_a;
    logic [AW-1:0]      rd_b;
    logic [DATA_W-1:0]  imm;
    logic [OP_W-1:0]    op;

    prog_sequencer #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W),
        .NREGS  (NREGS),
        .DEPTH  (DEPTH),
        .LOOP_W (LOOP_W)
    ) dut (
        .clk        (clk),
        .clr        (clr),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .start      (start),
        .loop_init  (loop_init),
        .step_mode  (step_mode),
        .step       (step),
        .busy       (busy),
        .done       (done),
        .pc         (pc),
        .sel_imm    (sel_imm),
        .ld_en      (ld_en),
        .ld_reg     (ld_reg),
        .rd_a       (rd_a),
        .rd_b       (rd_b),
        .imm        (imm),
        .op         (op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pulses = 0;
    bit step_test = 0;
    logic step_prev = 1'b0;
    logic [28:0] sb_q[$];
    logic [28:0] mon_exp;
    logic [INSTR_W-1:0] model_mem [DEPTH];
    logic [INSTR_W-1:0] fib_mem [DEPTH];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] mk(input logic [1:0] k, input logic s, input logic w,
                                       input logic [3:0] wa, input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [7:0] im, input logic [7:0] o);
        return {k, s, w, wa, ra, rb, im, o};
    endfunction

    always @(posedge clk) step_prev <= step;

    // Monitor: every register write must match the next predicted write.
    always @(negedge clk) begin
        if (ld_en === 1'b1) begin
            pulses++;
            if (step_test) check("step_gate", {63'd0, step_prev}, 64'd1);
            if (sb_q.size() == 0) begin
                check("unexpected_ld_en", 64'd1, 64'd0);
            end else begin
                mon_exp = sb_q.pop_front();
                check("ld_ctrl", {35'd0, sel_imm, ld_reg, rd_a, rd_b, imm, op}, {35'd0, mon_exp});
            end
        end
    end

    // Program-level reference: walks the table by the instruction rules and
    // queues the {sel_imm, wr_addr, ra, rb, imm, op} of every write it issues.
    task automatic model(input logic [7:0] li, output int n, output int hpc);
        int p;
        int cnt;
        bit fin;
        logic [31:0] ins;
        p = 0;
        cnt = int'(li);
        n = 0;
        fin = 0;
        while (!fin && n < 5000) begin
            ins = model_mem[p];
            n++;
            case (ins[31:30])
                2'b00: begin
                    if (ins[28]) sb_q.push_back({ins[29], ins[27:0]});
                    if (p == DEPTH - 1) fin = 1; else p++;
                end
                2'b01: p = int'(ins[12:8]);
                2'b11: begin
                    if (cnt != 0) begin
                        cnt--;
                        p = int'(ins[12:8]);
                    end else if (p == DEPTH - 1) fin = 1;
                    else p++;
                end
                default: fin = 1;
            endcase
        end
        hpc = p;
    endtask

    task automatic load(input int a, input logic [31:0] d);
        prog_we = 1'b1;
        prog_addr = PC_W'(a);
        prog_wdata = d;
        model_mem[a] = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic load_fib();
        for (int i = 0; i < 17; i++) load(i, fib_mem[i]);
    endtask

    // Issues start (optionally with a same-cycle program write) and returns the
    // predicted number of consumed instructions and the halting pc.
    task automatic launch(input logic [7:0] li, input bit sm, input bit cw, input int ca,
                          input logic [31:0] cd, output int n, output int hpc);
        if (cw) model_mem[ca] = cd;
        model(li, n, hpc);
        start = 1'b1;
        loop_init = li;
        step_mode = sm;
        prog_we = cw;
        prog_addr = PC_W'(ca);
        prog_wdata = cd;
        @(negedge clk);
        start = 1'b0;
        prog_we = 1'b0;
        step_mode = ~sm;  // must not influence the run already started
        loop_init = $urandom_range(0, 255);
    endtask

    task automatic finish_checks(input string tag, input int hpc);
        check({tag, "_pc"}, {59'd0, pc}, hpc);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_drain"}, sb_q.size(), 64'd0);
    endtask

    task automatic wait_run(input int n, input int hpc, input int elapsed, input string tag);
        int k;
        k = elapsed;
        while (done !== 1'b1 && k < n + 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_cycles"}, k, n);
        finish_checks(tag, hpc);
    endtask

    task automatic wait_step(input int n, input int hpc, input string tag);
        int steps;
        steps = 0;
        while (done !== 1'b1 && steps < n + 10) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            steps++;
            if (done === 1'b1) break;
            repeat (4) @(negedge clk);
        end
        check({tag, "_steps"}, steps, n);
        finish_checks(tag, hpc);
    endtask

    int n_exp;
    int h_exp;
    int p0;
    int k;
    logic [31:0] w;
    logic [31:0] new3;

    initial begin
        clr = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        start = 1'b0; loop_init = '0; step_mode = 1'b0; step = 1'b0;
        fib_mem[0] = mk(EXEC, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 8'd1, ADDI);
        fib_mem[1] = mk(EXEC, 1'b1, 1'b1, 4'd1, 4'd0, 4'd0, 8'd1, ADDI);
        for (int i = 2; i < 16; i++)
            fib_mem[i] = mk(EXEC, 1'b0, 1'b1, 4'(i), 4'(i - 1), 4'(i - 2), 8'd0, ADD);
        fib_mem[16] = mk(HALT, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_pc", {59'd0, pc}, 64'd0);
        check("rst_ld_en", {63'd0, ld_en}, 64'd0);
        check("rst_ctrl", {35'd0, sel_imm, ld_reg, rd_a, rd_b, imm, op}, 64'd0);
        clr = 1'b0;
        @(negedge clk);

        // Fibonacci, free running
        load_fib();
        p0 = pulses;
        launch(8'd0, 1'b0, 1'b0, 0, 32'd0, n_exp, h_exp);
        wait_run(n_exp, h_exp, 0, "fib");
        check("fib_pulses", pulses - p0, 64'd16);
        check("fib_halt_pc", {59'd0, pc}, 64'd16);

        // Counted loop, loop_init 3 then 0
        load(0, mk(EXEC, 1'b0, 1'b1, 4'd1, 4'd2, 4'd3, 8'h00, OR));
        load(1, mk(LOOP, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00));
        load(2, mk(HALT, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 8'h00, 8'h00));
        p0 = pulses;
        launch(8'd3, 1'b0, 1'b0, 0, 32'd0, n_exp, h_exp);
        wait_run(n_exp, h_exp, 0, "loop3");
        check("loop3_pulses", pulses - p0, 64'd4);
        p0 = pulses;
        launch(8'd0, 1'b0, 1'b0, 0, 32'd0, n_exp, h_exp);
        wait_run(n_exp, h_exp, 0, "loop0");
        check("loop0_pulses", pulses - p0, 64'd1);

        // Single-step Fibonacci
        load_fib();
        p0 = pulses;
        step_test = 1;
        launch(8'd0, 1'b1, 1'b0, 0, 32'd0, n_exp, h_exp);
        wait_step(n_exp, h_exp, "step");
        step_test = 0;
        check("step_pulses", pulses - p0, 64'd16);

        // Write protection while busy, then rewrite after halt
        new3 = mk(EXEC, 1'b0, 1'b1, 4'd9, 4'd1, 4'd2, 8'h00, ADD);
        launch(8'd0, 1'b0, 1'b0, 0, 32'd0, n_exp, h_exp);
        @(negedge clk);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 5'd3; prog_wdata = new3;
        @(negedge clk);
        prog_we = 1'b0;
        wait_run(n_exp, h_exp, 3, "wp_busy");
        load(3, new3);
        launch(8'd0, 1'b0, 1'b0, 0, 32'd0, n_exp, h_exp);
        wait_run(n_exp, h_exp, 0, "wp_after");
        load(3, fib_mem[3]);

        // Abort at the 6th write, then restart from retained memory
        p0 = pulses;
        launch(8'd0, 1'b0, 1'b0, 0, 32'd0, n_exp, h_exp);
        k = 0;
        while (pulses - p0 < 6 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("clr_at_6th", pulses - p0, 64'd6);
        clr = 1'b1;
        @(negedge clk);
        check("clr_busy", {63'd0, busy}, 64'd0);
        check("clr_pc", {59'd0, pc}, 64'd0);
        check("clr_ld_en", {63'd0, ld_en}, 64'd0);
        clr = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("clr_no_more", pulses - p0, 64'd6);
        p0 = pulses;
        launch(8'd0, 1'b0, 1'b0, 0, 32'd0, n_exp, h_exp);
        wait_run(n_exp, h_exp, 0, "restart");
        check("restart_pulses", pulses - p0, 64'd16);

        // clr and start together: clr wins
        clr = 1'b1; start = 1'b1;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        @(negedge clk);
        check("clr_start_busy", {63'd0, busy}, 64'd0);
        check("clr_start_done", {63'd0, done}, 64'd0);

        // DEPTH EXECs without HALT, with a stray start mid-run
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            w[31:30] = EXEC;
            w[28] = 1'b1;
            load(i, w);
        end
        p0 = pulses;
        launch(8'd0, 1'b0, 1'b0, 0, 32'd0, n_exp, h_exp);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_run(n_exp, h_exp, 5, "full");
        check("full_pulses", pulses - p0, DEPTH);
        check("full_pc", {59'd0, pc}, DEPTH - 1);

        // Randomised programs: forward jumps, backward loops, random fields
        for (int it = 0; it < 6; it++) begin
            for (int a = 1; a < DEPTH; a++) begin
                int r;
                int t;
                w = $urandom;
                r = $urandom_range(0, 9);
                if (r <= 5 || (r == 6 && a == DEPTH - 1)) begin
                    w[31:30] = EXEC;
                end else if (r == 6) begin
                    t = a + $urandom_range(1, 3);
                    if (t > DEPTH - 1) t = DEPTH - 1;
                    w[31:30] = JUMP;
                    w[12:8] = 5'(t);
                end else if (r <= 8) begin
                    t = a - $urandom_range(0, 3);
                    if (t < 0) t = 0;
                    w[31:30] = LOOP;
                    w[12:8] = 5'(t);
                end else begin
                    w[31:30] = HALT;
                end
                load(a, w);
            end
            w = $urandom;
            w[31:30] = EXEC;
            if (it[0]) begin
                step_test = 1;
                launch(8'($urandom_range(0, 3)), 1'b1, 1'b1, 0, w, n_exp, h_exp);
                wait_step(n_exp, h_exp, "rnd_step");
                step_test = 0;
            end else begin
                launch(8'($urandom_range(0, 3)), 1'b0, 1'b1, 0, w, n_exp, h_exp);
                wait_run(n_exp, h_exp, 0, "rnd_run");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
